inst_fetch_fifo: RTL and testbench
==================================

// Module: inst_fetch_fifo
// PURPOSE
//  Instruction buffer between the fetch stage and the dual-issue decode stage.
//  Accepts 0-2 fetched instructions per cycle and presents the oldest 2 to decode.
//  Returns occupancy status (full / 1 left / 2 left) to the global pipeline control.
//  The global control turns that status into en_if / en_if_id, which come back here as push/pop qualifiers.
// PARAMETERS
//  DEPTH   8   entries; power of two, >= 4
//  AW      3   log2(DEPTH); pointer width
// PORTS
//  clk          in   1    clock, rising edge
//  resetn       in   1    reset, synchronous, active-low
//  flush        in   1    branch taken / exception: discard all contents
//  push_cnt     in   2    instructions offered this cycle (0,1,2); 3 treated as 0
//  push_pc      in   32   PC of first offered instruction; second is push_pc+4
//  push_inst0   in   32   first offered instruction
//  push_inst1   in   32   second offered instruction
//  push_ack     out  1    offered group accepted this cycle (combinational)
//  pop_cnt      in   2    instructions consumed by decode this cycle (0,1,2); 3 treated as 0
//  out_valid0   out  1    head entry valid
//  out_valid1   out  1    head+1 entry valid
//  out_pc0      out  32   PC of head entry
//  out_inst0    out  32   instruction of head entry
//  out_pc1      out  32   PC of head+1 entry
//  out_inst1    out  32   instruction of head+1 entry
//  count        out  AW+1 current occupancy
//  fifo_empty   out  1    count==0
//  fifo_full    out  1    count==DEPTH
//  fifo_1_left  out  1    count==DEPTH-1
//  fifo_2_left  out  1    count==DEPTH-2
// BEHAVIOUR
//  Storage: DEPTH x {pc[31:0], inst[31:0]}; rd_ptr/wr_ptr are AW bits and wrap mod DEPTH.
//  Output path: first-word-fall-through.
//   - out_*0 is driven from rd_ptr and out_*1 from rd_ptr+1 (wrapped).
//   - out_valid0 = count>=1; out_valid1 = count>=2. Data is don't-care when the matching valid is 0.
//  Pop: effective pop = min(pop_cnt, count), evaluated on the pre-edge count.
//   - rd_ptr += effective pop.
//   - Popping an empty entry is a no-op, not an error.
//  Push:
//   - push_ack = resetn & ~flush & (push_cnt!=0) & (DEPTH-count >= push_cnt).
//   - Free space is taken from the pre-edge count. A same-cycle pop does NOT create space (no bypass).
//   - A group is all-or-nothing: there are no partial pushes.
//   - When acked, entry wr_ptr <= {push_pc, push_inst0}.
//   - When push_cnt==2, entry wr_ptr+1 <= {push_pc+4, push_inst1}.
//   - wr_ptr += push_cnt.
//  Count: count_next = count + (ack ? push_cnt : 0) - effective pop; never exceeds DEPTH, never goes below 0.
//  Simultaneous push+pop on a full FIFO: the pop proceeds, the push is rejected (push_ack=0).
//   - The fetch side must re-present the same group.
//  Flush: on the next edge rd_ptr=wr_ptr=0 and count=0.
//   - Push and pop in the flush cycle are ignored; push_ack=0.
//   - Flush has priority over all other activity.
//  Reset (resetn=0 at an edge): rd_ptr=wr_ptr=0 and count=0; storage is not cleared.
//   - After reset: out_valid0/1=0, fifo_empty=1, fifo_full=fifo_1_left=fifo_2_left=0, push_ack=0.
//   - Reset mid-operation drops all contents exactly like flush.
//  Status flags are registered-count decodes. At most one of full/1_left/2_left is high at a time.
//  Wrap: a two-entry push or pop straddling index DEPTH-1 -> 0 is legal and must preserve order.
// TESTING
//  1. Reset, push_cnt=2 pc=0x1000 inst=A,B -> ack=1; next cycle count=2, out_pc0=0x1000, out_pc1=0x1004, inst A,B.
//  2. Fill with 4 pushes of 2 -> count=8, fifo_full=1; push_cnt=1 -> ack=0; pop 2 -> count=6, fifo_2_left=1.
//  3. count=7: push_cnt=2 with pop_cnt=2 in the same cycle -> ack=0, count=5.
//     Then push_cnt=1 -> ack=1, count=6.
//  4. Wrap: set rd=wr=7 (count=0), push 2 pc=0x2000 -> entries 7,0.
//     Pop 2 -> out PCs 0x2000, 0x2004 in order; count=0.
//  5. count=5, flush with push_cnt=2 and pop_cnt=1 -> ack=0; next cycle count=0, fifo_empty=1, out_valid0=0.
//  6. count=1, pop_cnt=2 -> count=0, no underflow; pop on empty -> rd_ptr unchanged.
//     resetn=0 with count=6 -> count=0.

Source files
------------

// File: rtl/inst_fetch_fifo.sv
// inst_fetch_fifo: dual-issue FWFT instruction buffer, 0-2 push / 0-2 pop per cycle, all-or-nothing push groups, occupancy flags for pipeline control
module inst_fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic [1:0]    push_cnt,
  input  logic [31:0]   push_pc,
  input  logic [31:0]   push_inst0,
  input  logic [31:0]   push_inst1,
  output logic          push_ack,
  input  logic [1:0]    pop_cnt,
  output logic          out_valid0,
  output logic          out_valid1,
  output logic [31:0]   out_pc0,
  output logic [31:0]   out_inst0,
  output logic [31:0]   out_pc1,
  output logic [31:0]   out_inst1,
  output logic [AW:0]   count,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          fifo_1_left,
  output logic          fifo_2_left
);
  localparam logic [AW-1:0] ONE = 1;
  logic [31:0] pc_mem [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd1, wr1;
  logic [1:0] pcnt, ocnt, epop;
  assign pcnt = push_cnt == 2'd3 ? 2'd0 : push_cnt;
  assign ocnt = pop_cnt == 2'd3 ? 2'd0 : pop_cnt;
  assign epop = (AW+1)'(ocnt) > count ? count[1:0] : ocnt;
  assign push_ack = resetn & ~flush & (pcnt != 2'd0) & ((AW+1)'(DEPTH) - count >= (AW+1)'(pcnt));
  assign rd1 = rd_ptr + ONE;
  assign wr1 = wr_ptr + ONE;
  always_ff @(posedge clk) begin
    if (push_ack) begin
      pc_mem[wr_ptr] <= push_pc;
      inst_mem[wr_ptr] <= push_inst0;
      if (pcnt == 2'd2) begin
        pc_mem[wr1] <= push_pc + 32'd4;
        inst_mem[wr1] <= push_inst1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(epop);
      wr_ptr <= push_ack ? wr_ptr + AW'(pcnt) : wr_ptr;
      count <= count + (AW+1)'(push_ack ? pcnt : 2'd0) - (AW+1)'(epop);
    end
  end
  always_comb begin
    out_pc0 = pc_mem[rd_ptr];
    out_inst0 = inst_mem[rd_ptr];
    out_pc1 = pc_mem[rd1];
    out_inst1 = inst_mem[rd1];
    out_valid0 = count >= (AW+1)'(1);
    out_valid1 = count >= (AW+1)'(2);
    fifo_empty = count == '0;
    fifo_full = count == (AW+1)'(DEPTH);
    fifo_1_left = count == (AW+1)'(DEPTH-1);
    fifo_2_left = count == (AW+1)'(DEPTH-2);
  end
endmodule

// File: tb/tb_inst_fetch_fifo.sv
// tb_inst_fetch_fifo: directed and randomized checks of inst_fetch_fifo against a queue-based reference model
module tb_inst_fetch_fifo;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  logic clk = 0, resetn = 0, flush = 0;
  logic [1:0] push_cnt = 0, pop_cnt = 0;
  logic [31:0] push_pc = 0, push_inst0 = 0, push_inst1 = 0;
  logic push_ack, out_valid0, out_valid1, fifo_empty, fifo_full, fifo_1_left, fifo_2_left;
  logic [31:0] out_pc0, out_inst0, out_pc1, out_inst1;
  logic [AW:0] count;
  int checks = 0, errors = 0;
  bit chk_on = 0;
  logic [63:0] q[$];

  inst_fetch_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .push_cnt(push_cnt), .push_pc(push_pc),
    .push_inst0(push_inst0), .push_inst1(push_inst1), .push_ack(push_ack), .pop_cnt(pop_cnt),
    .out_valid0(out_valid0), .out_valid1(out_valid1), .out_pc0(out_pc0), .out_inst0(out_inst0),
    .out_pc1(out_pc1), .out_inst1(out_inst1), .count(count), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_1_left(fifo_1_left), .fifo_2_left(fifo_2_left)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit exp_ack();
    return resetn === 1'b1 && flush === 1'b0 && (push_cnt == 2'd1 || push_cnt == 2'd2)
           && (DEPTH - q.size() >= int'(push_cnt));
  endfunction

  always @(posedge clk) begin
    automatic bit a = exp_ack();
    automatic int n = (pop_cnt == 2'd3) ? 0 : int'(pop_cnt);
    if (!resetn || flush) q.delete();
    else begin
      if (n > q.size()) n = q.size();
      repeat (n) void'(q.pop_front());
      if (a) begin
        q.push_back({push_pc, push_inst0});
        if (push_cnt == 2'd2) q.push_back({push_pc + 32'd4, push_inst1});
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("count", 32'(count), q.size());
    chk("valid0", 32'(out_valid0), 32'(q.size() >= 1));
    chk("valid1", 32'(out_valid1), 32'(q.size() >= 2));
    chk("empty", 32'(fifo_empty), 32'(q.size() == 0));
    chk("full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("1_left", 32'(fifo_1_left), 32'(q.size() == DEPTH - 1));
    chk("2_left", 32'(fifo_2_left), 32'(q.size() == DEPTH - 2));
    chk("push_ack", 32'(push_ack), 32'(exp_ack()));
    if (q.size() >= 1) begin
      chk("pc0", out_pc0, q[0][63:32]);
      chk("inst0", out_inst0, q[0][31:0]);
    end
    if (q.size() >= 2) begin
      chk("pc1", out_pc1, q[1][63:32]);
      chk("inst1", out_inst1, q[1][31:0]);
    end
  end

  task automatic drv(logic rn, logic fl, logic [1:0] pc_n, logic [31:0] pc, logic [1:0] po);
    resetn = rn;
    flush = fl;
    push_cnt = pc_n;
    push_pc = pc;
    push_inst0 = $urandom;
    push_inst1 = $urandom;
    pop_cnt = po;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 2, 32'h1000, 0);
    tick();
    chk_on = 1;
    tick();
    chk("rst count", 32'(count), 0);
    chk("rst empty", 32'(fifo_empty), 1);
    chk("rst valid0", 32'(out_valid0), 0);
    chk("rst full", 32'(fifo_full), 0);
    chk("rst ack", 32'(push_ack), 0);
    drv(1, 0, 2, 32'h1000, 0);
    push_inst0 = 32'hAAAA_0000;
    push_inst1 = 32'hBBBB_0001;
    #1;
    chk("t1 ack", 32'(push_ack), 1);
    tick();
    chk("t1 count", 32'(count), 2);
    chk("t1 pc0", out_pc0, 32'h1000);
    chk("t1 pc1", out_pc1, 32'h1004);
    chk("t1 inst0", out_inst0, 32'hAAAA_0000);
    chk("t1 inst1", out_inst1, 32'hBBBB_0001);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 2, 32'h1008 + 32'(i * 8), 0);
      tick();
    end
    chk("t2 count", 32'(count), 8);
    chk("t2 full", 32'(fifo_full), 1);
    drv(1, 0, 1, 32'h3000, 0);
    chk("t2 ack", 32'(push_ack), 0);
    tick();
    drv(1, 0, 0, 0, 2);
    tick();
    chk("t2 count6", 32'(count), 6);
    chk("t2 2left", 32'(fifo_2_left), 1);
    drv(1, 0, 1, 32'h4000, 0);
    tick();
    chk("t3 count7", 32'(count), 7);
    chk("t3 1left", 32'(fifo_1_left), 1);
    drv(1, 0, 2, 32'h5000, 2);
    chk("t3 ack", 32'(push_ack), 0);
    tick();
    chk("t3 count5", 32'(count), 5);
    drv(1, 0, 1, 32'h5000, 0);
    chk("t3 ack1", 32'(push_ack), 1);
    tick();
    chk("t3 count6", 32'(count), 6);
    drv(1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 2, 32'h100 + 32'(i * 8), 0);
      tick();
    end
    drv(1, 0, 1, 32'h200, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0, 2);
      tick();
    end
    drv(1, 0, 0, 0, 1);
    tick();
    chk("t4 count0", 32'(count), 0);
    drv(1, 0, 2, 32'h2000, 0);
    tick();
    chk("t4 wrap pc0", out_pc0, 32'h2000);
    chk("t4 wrap pc1", out_pc1, 32'h2004);
    drv(1, 0, 0, 0, 2);
    tick();
    chk("t4 count", 32'(count), 0);
    drv(1, 0, 2, 32'h6000, 0);
    tick();
    drv(1, 0, 2, 32'h6008, 0);
    tick();
    drv(1, 0, 1, 32'h6010, 0);
    tick();
    chk("t5 count5", 32'(count), 5);
    drv(1, 1, 2, 32'h7000, 1);
    chk("t5 ack", 32'(push_ack), 0);
    tick();
    chk("t5 count", 32'(count), 0);
    chk("t5 empty", 32'(fifo_empty), 1);
    chk("t5 valid0", 32'(out_valid0), 0);
    drv(1, 0, 1, 32'h8000, 0);
    tick();
    drv(1, 0, 0, 0, 2);
    tick();
    chk("t6 count", 32'(count), 0);
    drv(1, 0, 0, 0, 2);
    tick();
    drv(1, 0, 1, 32'h8100, 0);
    tick();
    chk("t6 pc0", out_pc0, 32'h8100);
    drv(1, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 2, 32'h9000 + 32'(i * 8), 0);
      tick();
    end
    chk("t6 count6", 32'(count), 6);
    drv(0, 0, 0, 0, 0);
    tick();
    chk("t6 rst count", 32'(count), 0);
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(63) != 0, $urandom_range(31) == 0, 2'($urandom_range(3)),
          $urandom & ~32'd3, 2'($urandom_range(3)));
      tick();
    end
    drv(1, 0, 0, 0, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
